// File: rtl/vga_timing_generator.sv
// -----------------------------------------------------------------------------
// vga_timing_generator
//
// Parametrised horizontal/vertical raster timing for a pixel-clock domain.
// Produces sync pulses of programmable polarity, display enable, raw pixel
// coordinates and one-cycle line/frame start strobes.
//
// Every output is a register. The decode for the sync/enable/strobe registers
// is taken from the next-state counter values, so in any cycle h_sync, v_sync
// and display_enable describe exactly the pixel_x/pixel_y shown in that cycle.
//
// Optional build macro:
//   VGA_TIMING_FRAME_CNT_EN - adds a 16-bit wrapping frame_count output that
//                             increments on every frame_start cycle.
// -----------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int H_POL        = 0,
    parameter int V_POL        = 0,
    parameter int COUNTER_SIZE = 11
) (
    input  logic                    control_clock,
    input  logic                    reset_n,
    input  logic                    enable,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    display_enable,
    output logic [COUNTER_SIZE-1:0] pixel_x,
    output logic [COUNTER_SIZE-1:0] pixel_y,
    output logic                    line_start,
    output logic                    frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]             frame_count
`endif
);

    // -------------------------------------------------------------------------
    // Derived timing constants
    // -------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COUNTER_SIZE-1:0] CNT_ZERO     = COUNTER_SIZE'(0);
    localparam logic [COUNTER_SIZE-1:0] CNT_ONE      = COUNTER_SIZE'(1);

    localparam logic [COUNTER_SIZE-1:0] H_LAST       = COUNTER_SIZE'(H_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] H_ACT_END    = COUNTER_SIZE'(H_ACTIVE);
    localparam logic [COUNTER_SIZE-1:0] H_SYNC_FIRST = COUNTER_SIZE'(H_ACTIVE + H_FP);
    localparam logic [COUNTER_SIZE-1:0] H_SYNC_LAST  = COUNTER_SIZE'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [COUNTER_SIZE-1:0] V_LAST       = COUNTER_SIZE'(V_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] V_ACT_END    = COUNTER_SIZE'(V_ACTIVE);
    localparam logic [COUNTER_SIZE-1:0] V_SYNC_FIRST = COUNTER_SIZE'(V_ACTIVE + V_FP);
    localparam logic [COUNTER_SIZE-1:0] V_SYNC_LAST  = COUNTER_SIZE'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Asserted and idle levels of the two sync outputs
    localparam logic H_ON  = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic H_OFF = (H_POL != 0) ? 1'b0 : 1'b1;
    localparam logic V_ON  = (V_POL != 0) ? 1'b1 : 1'b0;
    localparam logic V_OFF = (V_POL != 0) ? 1'b0 : 1'b1;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // -------------------------------------------------------------------------
    if ((COUNTER_SIZE < 1) || (COUNTER_SIZE > 30)) begin : g_bad_counter_size
        $error("vga_timing_generator: COUNTER_SIZE must be within 1..30");
    end

    if ((H_ACTIVE <= 0) || (H_FP <= 0) || (H_SYNC <= 0) || (H_BP <= 0)) begin : g_bad_h_params
        $error("vga_timing_generator: horizontal active/porch/sync widths must be non-zero");
    end

    if ((V_ACTIVE <= 0) || (V_FP <= 0) || (V_SYNC <= 0) || (V_BP <= 0)) begin : g_bad_v_params
        $error("vga_timing_generator: vertical active/porch/sync widths must be non-zero");
    end

    if ((H_TOTAL - 1) >= (1 << COUNTER_SIZE)) begin : g_h_overflow
        $error("vga_timing_generator: H_TOTAL-1 does not fit in COUNTER_SIZE bits");
    end

    if ((V_TOTAL - 1) >= (1 << COUNTER_SIZE)) begin : g_v_overflow
        $error("vga_timing_generator: V_TOTAL-1 does not fit in COUNTER_SIZE bits");
    end

    // -------------------------------------------------------------------------
    // Decode helpers
    // -------------------------------------------------------------------------
    // Inclusive window test on an unsigned position
    function automatic logic in_window(
        input logic [COUNTER_SIZE-1:0] pos,
        input logic [COUNTER_SIZE-1:0] first,
        input logic [COUNTER_SIZE-1:0] last
    );
        in_window = (pos >= first) && (pos <= last);
    endfunction

    // Wrapping increment of a position counter
    function automatic logic [COUNTER_SIZE-1:0] wrap_inc(
        input logic [COUNTER_SIZE-1:0] pos,
        input logic [COUNTER_SIZE-1:0] last
    );
        if (pos == last) begin
            wrap_inc = CNT_ZERO;
        end else begin
            wrap_inc = pos + CNT_ONE;
        end
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [COUNTER_SIZE-1:0] h_count_r;
    logic [COUNTER_SIZE-1:0] v_count_r;
    logic                    h_sync_r;
    logic                    v_sync_r;
    logic                    display_enable_r;
    logic                    line_start_r;
    logic                    frame_start_r;

    logic [COUNTER_SIZE-1:0] h_next_s;
    logic [COUNTER_SIZE-1:0] v_next_s;
    logic                    h_wrap_s;
    logic                    h_sync_next_s;
    logic                    v_sync_next_s;
    logic                    display_enable_next_s;
    logic                    line_start_next_s;
    logic                    frame_start_next_s;

    // Next raster position: hold when not enabled, v steps only on the h wrap
    always_comb begin
        h_next_s = h_count_r;
        v_next_s = v_count_r;
        h_wrap_s = (h_count_r == H_LAST);
        if (enable) begin
            h_next_s = wrap_inc(h_count_r, H_LAST);
            if (h_wrap_s) begin
                v_next_s = wrap_inc(v_count_r, V_LAST);
            end else begin
                v_next_s = v_count_r;
            end
        end else begin
            h_next_s = h_count_r;
            v_next_s = v_count_r;
        end
    end

    // Region and strobe decode of the position that becomes visible next cycle
    always_comb begin
        h_sync_next_s         = H_OFF;
        v_sync_next_s         = V_OFF;
        display_enable_next_s = 1'b0;
        line_start_next_s     = 1'b0;
        frame_start_next_s    = 1'b0;

        if (in_window(h_next_s, H_SYNC_FIRST, H_SYNC_LAST)) begin
            h_sync_next_s = H_ON;
        end else begin
            h_sync_next_s = H_OFF;
        end

        if (in_window(v_next_s, V_SYNC_FIRST, V_SYNC_LAST)) begin
            v_sync_next_s = V_ON;
        end else begin
            v_sync_next_s = V_OFF;
        end

        display_enable_next_s = (h_next_s < H_ACT_END) && (v_next_s < V_ACT_END);

        // Strobes fire only on an enabled cycle that actually enters column 0,
        // so a stalled pixel at column 0 never stretches them.
        if (enable && h_wrap_s) begin
            line_start_next_s  = 1'b1;
            frame_start_next_s = (v_next_s == CNT_ZERO);
        end else begin
            line_start_next_s  = 1'b0;
            frame_start_next_s = 1'b0;
        end
    end

    // Position counters; reset parks on the last back-porch pixel of the frame
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count_r <= H_LAST;
            v_count_r <= V_LAST;
        end else begin
            h_count_r <= h_next_s;
            v_count_r <= v_next_s;
        end
    end

    // Registered sync, enable and strobe outputs aligned with the counters
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_sync_r         <= H_OFF;
            v_sync_r         <= V_OFF;
            display_enable_r <= 1'b0;
            line_start_r     <= 1'b0;
            frame_start_r    <= 1'b0;
        end else begin
            h_sync_r         <= h_sync_next_s;
            v_sync_r         <= v_sync_next_s;
            display_enable_r <= display_enable_next_s;
            line_start_r     <= line_start_next_s;
            frame_start_r    <= frame_start_next_s;
        end
    end

    assign h_sync         = h_sync_r;
    assign v_sync         = v_sync_r;
    assign display_enable = display_enable_r;
    assign pixel_x        = h_count_r;
    assign pixel_y        = v_count_r;
    assign line_start     = line_start_r;
    assign frame_start    = frame_start_r;

`ifdef VGA_TIMING_FRAME_CNT_EN
    // -------------------------------------------------------------------------
    // Frame counter: steps in the same cycle frame_start asserts
    // -------------------------------------------------------------------------
    logic [15:0] frame_count_r;
    logic [15:0] frame_count_next_s;

    // Increment on the frame boundary, natural 16-bit wrap
    always_comb begin
        frame_count_next_s = frame_count_r;
        if (frame_start_next_s) begin
            frame_count_next_s = frame_count_r + 16'd1;
        end else begin
            frame_count_next_s = frame_count_r;
        end
    end

    // Frame counter register
    always_ff @(posedge control_clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_r <= 16'd0;
        end else begin
            frame_count_r <= frame_count_next_s;
        end
    end

    assign frame_count = frame_count_r;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for vga_timing_generator.
// dut      : default 640x480 timing, active-low syncs
// dut_small: 8x4 active, 14x7 total, active-high syncs
// -----------------------------------------------------------------------------
module tb_vga_timing_generator;

    logic        clk;
    logic        reset_n;
    logic        enable;

    logic        h_sync;
    logic        v_sync;
    logic        display_enable;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        line_start;
    logic        frame_start;

    logic        s_h_sync;
    logic        s_v_sync;
    logic        s_display_enable;
    logic [10:0] s_pixel_x;
    logic [10:0] s_pixel_y;
    logic        s_line_start;
    logic        s_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count;
    logic [15:0] s_frame_count;
`endif

    int checks;
    int failures;

    vga_timing_generator dut (
        .control_clock  (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .h_sync         (h_sync),
        .v_sync         (v_sync),
        .display_enable (display_enable),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .line_start     (line_start),
        .frame_start    (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_count    (frame_count)
`endif
    );

    vga_timing_generator #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL    (1), .V_POL (1), .COUNTER_SIZE (11)
    ) dut_small (
        .control_clock  (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .h_sync         (s_h_sync),
        .v_sync         (s_v_sync),
        .display_enable (s_display_enable),
        .pixel_x        (s_pixel_x),
        .pixel_y        (s_pixel_y),
        .line_start     (s_line_start),
        .frame_start    (s_frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_count    (s_frame_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks = checks + 7;
        if (pixel_x !== 11'd799) begin failures++; $display("FAIL reset_pixel_x got %0d want 799", pixel_x); end
        if (pixel_y !== 11'd524) begin failures++; $display("FAIL reset_pixel_y got %0d want 524", pixel_y); end
        if (h_sync !== 1'b1) begin failures++; $display("FAIL reset_h_sync got %b want 1", h_sync); end
        if (v_sync !== 1'b1) begin failures++; $display("FAIL reset_v_sync got %b want 1", v_sync); end
        if (display_enable !== 1'b0) begin failures++; $display("FAIL reset_de got %b want 0", display_enable); end
        if (line_start !== 1'b0) begin failures++; $display("FAIL reset_line_start got %b want 0", line_start); end
        if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        checks = checks + 4;
        if (s_h_sync !== 1'b0) begin failures++; $display("FAIL reset_small_h_sync got %b want 0", s_h_sync); end
        if (s_v_sync !== 1'b0) begin failures++; $display("FAIL reset_small_v_sync got %b want 0", s_v_sync); end
        if (s_pixel_x !== 11'd13) begin failures++; $display("FAIL reset_small_x got %0d want 13", s_pixel_x); end
        if (s_pixel_y !== 11'd6) begin failures++; $display("FAIL reset_small_y got %0d want 6", s_pixel_y); end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
`endif
    endtask

    task automatic test_first_line();
        int low_cnt;
        int low_min;
        int low_max;
        int ls_cnt;
        low_cnt = 0; low_min = 9999; low_max = -1; ls_cnt = 0;
        reset_n = 1'b1;
        step();
        checks = checks + 5;
        if (pixel_x !== 11'd0) begin failures++; $display("FAIL first_x got %0d want 0", pixel_x); end
        if (pixel_y !== 11'd0) begin failures++; $display("FAIL first_y got %0d want 0", pixel_y); end
        if (frame_start !== 1'b1) begin failures++; $display("FAIL first_frame_start got %b want 1", frame_start); end
        if (line_start !== 1'b1) begin failures++; $display("FAIL first_line_start got %b want 1", line_start); end
        if (display_enable !== 1'b1) begin failures++; $display("FAIL first_de got %b want 1", display_enable); end
        for (int i = 0; i < 800; i++) begin
            if (h_sync === 1'b0) begin
                low_cnt++;
                if (int'(pixel_x) < low_min) low_min = int'(pixel_x);
                if (int'(pixel_x) > low_max) low_max = int'(pixel_x);
            end
            if (line_start === 1'b1) ls_cnt++;
            step();
        end
        checks = checks + 7;
        if (low_cnt != 96) begin failures++; $display("FAIL hsync_width got %0d want 96", low_cnt); end
        if (low_min != 656) begin failures++; $display("FAIL hsync_first got %0d want 656", low_min); end
        if (low_max != 751) begin failures++; $display("FAIL hsync_last got %0d want 751", low_max); end
        if (ls_cnt != 1) begin failures++; $display("FAIL line_start_per_line got %0d want 1", ls_cnt); end
        if (pixel_x !== 11'd0) begin failures++; $display("FAIL line1_x got %0d want 0", pixel_x); end
        if (pixel_y !== 11'd1) begin failures++; $display("FAIL line1_y got %0d want 1", pixel_y); end
        if (line_start !== 1'b1 || frame_start !== 1'b0) begin
            failures++; $display("FAIL line1_strobes got ls=%b fs=%b want ls=1 fs=0", line_start, frame_start);
        end
    endtask

    // Jump the default counters to line 489, then watch the v_sync window
    task automatic test_vsync_window();
        int low_cnt;
        low_cnt = 0;
        force dut.h_count_r = 11'd798;
        force dut.v_count_r = 11'd489;
        #1;
        release dut.h_count_r;
        release dut.v_count_r;
        step();
        checks = checks + 2;
        if (pixel_x !== 11'd799 || pixel_y !== 11'd489) begin
            failures++; $display("FAIL vs_pre_pos got %0d,%0d want 799,489", pixel_x, pixel_y);
        end
        if (v_sync !== 1'b1) begin failures++; $display("FAIL vs_pre_level got %b want 1", v_sync); end
        step();
        checks = checks + 2;
        if (pixel_x !== 11'd0 || pixel_y !== 11'd490) begin
            failures++; $display("FAIL vs_start_pos got %0d,%0d want 0,490", pixel_x, pixel_y);
        end
        if (v_sync !== 1'b0) begin failures++; $display("FAIL vs_start_level got %b want 0", v_sync); end
        low_cnt = 1;
        for (int i = 0; i < 1600; i++) begin
            step();
            if (v_sync === 1'b0) low_cnt++;
        end
        checks = checks + 3;
        if (low_cnt != 1600) begin failures++; $display("FAIL vs_width got %0d want 1600", low_cnt); end
        if (pixel_y !== 11'd492 || pixel_x !== 11'd0) begin
            failures++; $display("FAIL vs_end_pos got %0d,%0d want 0,492", pixel_x, pixel_y);
        end
        if (display_enable !== 1'b0) begin failures++; $display("FAIL vs_end_de got %b want 0", display_enable); end
    endtask

    task automatic test_frame_wrap();
        int cycles;
        cycles = 0;
        force dut.h_count_r = 11'd790;
        force dut.v_count_r = 11'd524;
        #1;
        release dut.h_count_r;
        release dut.v_count_r;
        while (cycles < 20) begin
            step();
            cycles++;
            if (frame_start === 1'b1) break;
        end
        checks = checks + 3;
        if (cycles != 10) begin failures++; $display("FAIL frame_wrap_cycles got %0d want 10", cycles); end
        if (pixel_x !== 11'd0 || pixel_y !== 11'd0) begin
            failures++; $display("FAIL frame_wrap_pos got %0d,%0d want 0,0", pixel_x, pixel_y);
        end
        if (line_start !== 1'b1) begin failures++; $display("FAIL frame_wrap_ls got %b want 1", line_start); end
    endtask

    task automatic test_enable_hold();
        apply_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 799; i++) step();
        checks++;
        if (pixel_x !== 11'd798 || pixel_y !== 11'd0) begin
            failures++; $display("FAIL hold_setup got %0d,%0d want 798,0", pixel_x, pixel_y);
        end
        enable = 1'b1;
        step();
        checks = checks + 2;
        if (pixel_x !== 11'd799) begin failures++; $display("FAIL hold_799 got %0d want 799", pixel_x); end
        if (line_start !== 1'b0) begin failures++; $display("FAIL hold_ls_799 got %b want 0", line_start); end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks = checks + 4;
            if (pixel_x !== 11'd799 || pixel_y !== 11'd0) begin
                failures++; $display("FAIL hold_pos got %0d,%0d want 799,0", pixel_x, pixel_y);
            end
            if (h_sync !== 1'b1 || v_sync !== 1'b1) begin
                failures++; $display("FAIL hold_sync got h=%b v=%b want 1,1", h_sync, v_sync);
            end
            if (display_enable !== 1'b0) begin failures++; $display("FAIL hold_de got %b want 0", display_enable); end
            if (line_start !== 1'b0 || frame_start !== 1'b0) begin
                failures++; $display("FAIL hold_strobe got ls=%b fs=%b want 0,0", line_start, frame_start);
            end
        end
        enable = 1'b1;
        step();
        checks = checks + 3;
        if (pixel_x !== 11'd0 || pixel_y !== 11'd1) begin
            failures++; $display("FAIL resume_pos got %0d,%0d want 0,1", pixel_x, pixel_y);
        end
        if (line_start !== 1'b1) begin failures++; $display("FAIL resume_ls got %b want 1", line_start); end
        if (display_enable !== 1'b1) begin failures++; $display("FAIL resume_de got %b want 1", display_enable); end
        step();
        checks++;
        if (line_start !== 1'b0) begin failures++; $display("FAIL resume_ls_next got %b want 0", line_start); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 701; i++) step();
        checks = checks + 2;
        if (pixel_x !== 11'd700) begin failures++; $display("FAIL async_setup_x got %0d want 700", pixel_x); end
        if (h_sync !== 1'b0) begin failures++; $display("FAIL async_setup_hs got %b want 0", h_sync); end
        #2;
        reset_n = 1'b0;
        #1;
        checks = checks + 4;
        if (h_sync !== 1'b1) begin failures++; $display("FAIL async_hs got %b want 1", h_sync); end
        if (pixel_x !== 11'd799) begin failures++; $display("FAIL async_x got %0d want 799", pixel_x); end
        if (pixel_y !== 11'd524) begin failures++; $display("FAIL async_y got %0d want 524", pixel_y); end
        if (display_enable !== 1'b0) begin failures++; $display("FAIL async_de got %b want 0", display_enable); end
        step();
    endtask

    // Small geometry: walk two frames against a bench-side raster model
    task automatic test_small_timing();
        int x;
        int y;
        int de_cnt;
        int fs_cycle;
        logic exp_hs;
        logic exp_vs;
        logic exp_de;
        logic exp_ls;
        logic exp_fs;
        x = 0; y = 0; de_cnt = 0; fs_cycle = -1;
        apply_reset();
        reset_n = 1'b1;
        for (int c = 0; c < 196; c++) begin
            step();
            exp_hs = (x >= 10 && x <= 12);
            exp_vs = (y == 5);
            exp_de = (x < 8 && y < 4);
            exp_ls = (x == 0);
            exp_fs = (x == 0 && y == 0);
            checks = checks + 3;
            if (s_pixel_x !== 11'(x) || s_pixel_y !== 11'(y)) begin
                failures++; $display("FAIL small_pos c=%0d got %0d,%0d want %0d,%0d", c, s_pixel_x, s_pixel_y, x, y);
            end
            if (s_h_sync !== exp_hs || s_v_sync !== exp_vs || s_display_enable !== exp_de) begin
                failures++;
                $display("FAIL small_decode c=%0d got hs=%b vs=%b de=%b want hs=%b vs=%b de=%b",
                         c, s_h_sync, s_v_sync, s_display_enable, exp_hs, exp_vs, exp_de);
            end
            if (s_line_start !== exp_ls || s_frame_start !== exp_fs) begin
                failures++;
                $display("FAIL small_strobe c=%0d got ls=%b fs=%b want ls=%b fs=%b",
                         c, s_line_start, s_frame_start, exp_ls, exp_fs);
            end
            if (c < 98 && s_display_enable === 1'b1) de_cnt++;
            if (c > 0 && s_frame_start === 1'b1 && fs_cycle < 0) fs_cycle = c;
            x = (x == 13) ? 0 : x + 1;
            if (x == 0) y = (y == 6) ? 0 : y + 1;
        end
        checks = checks + 2;
        if (de_cnt != 32) begin failures++; $display("FAIL small_de_count got %0d want 32", de_cnt); end
        if (fs_cycle != 98) begin failures++; $display("FAIL small_frame_len got %0d want 98", fs_cycle); end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_count();
        int guard;
        apply_reset();
        reset_n = 1'b1;
        step();
        checks++;
        if (s_frame_start !== 1'b1 || s_frame_count !== 16'd1) begin
            failures++; $display("FAIL fc_first got fs=%b fc=%0d want 1,1", s_frame_start, s_frame_count);
        end
        for (int f = 2; f <= 3; f++) begin
            guard = 0;
            do begin step(); guard++; end while (s_frame_start !== 1'b1 && guard < 200);
            checks = checks + 2;
            if (guard != 98) begin failures++; $display("FAIL fc_period got %0d want 98", guard); end
            if (s_frame_count !== 16'(f)) begin failures++; $display("FAIL fc_frame got %0d want %0d", s_frame_count, f); end
        end
        enable = 1'b0;
        step();
        checks++;
        if (s_frame_count !== 16'd3) begin failures++; $display("FAIL fc_hold got %0d want 3", s_frame_count); end
        enable = 1'b1;
        force dut_small.frame_count_r = 16'hFFFF;
        #1;
        release dut_small.frame_count_r;
        guard = 0;
        do begin step(); guard++; end while (s_frame_start !== 1'b1 && guard < 200);
        checks++;
        if (s_frame_count !== 16'd0) begin failures++; $display("FAIL fc_wrap got %0d want 0", s_frame_count); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        test_reset();
        test_first_line();
        test_vsync_window();
        test_frame_wrap();
        test_enable_hold();
        test_async_reset();
        test_small_timing();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
